// File: rtl/key_req_arbiter_pkg.sv
// Shared widths and FSM state encoding for the key request arbiter.
package key_req_arbiter_pkg;

  localparam int unsigned KEY_WIDTH         = 256;
  localparam int unsigned KEY_ID_WIDTH      = 32;
  localparam int unsigned TIMEOUT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/key_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request above i_last, wrapping.
module key_req_arbiter_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [IDX_W-1:0]     o_grant,
  output logic                 o_valid
);

  int unsigned w_idx;

  // Scan from i_last+1 upward modulo NUM_PORTS; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      w_idx = (32'(i_last) + k) % NUM_PORTS;
      if (!o_valid && i_req[IDX_W'(w_idx)]) begin
        o_grant = IDX_W'(w_idx);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_req_arbiter.sv
// Round-robin arbiter forwarding per-path key requests to a single keymem port.
module key_req_arbiter
  import key_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk156,
  input  logic                              areset_clk156,
  input  logic [NUM_PORTS-1:0]              up_key_req,
  input  logic [NUM_PORTS*KEY_ID_WIDTH-1:0] up_key_id,
  output logic [NUM_PORTS-1:0]              up_key_ack,
  output logic [NUM_PORTS-1:0]              up_key_err,
  output logic [KEY_WIDTH-1:0]              up_key,
  output logic                              dn_key_req,
  output logic [KEY_ID_WIDTH-1:0]           dn_key_id,
  input  logic                              dn_key_ack,
  input  logic [KEY_WIDTH-1:0]              dn_key,
  output logic                              busy,
  output logic [TIMEOUT_CNT_WIDTH-1:0]      timeout_count
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TMO_LAST = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                         r_state;
  state_t                         w_next;
  logic [IDX_W-1:0]               r_grant;
  logic [IDX_W-1:0]               r_last_grant;
  logic [TIMEOUT_CNT_WIDTH-1:0]   r_tcnt;
  logic [TIMEOUT_CNT_WIDTH-1:0]   r_timeout_count;
  logic [NUM_PORTS-1:0]           r_up_key_ack;
  logic [NUM_PORTS-1:0]           r_up_key_err;
  logic [KEY_WIDTH-1:0]           r_up_key;
  logic                           r_dn_key_req;
  logic [KEY_ID_WIDTH-1:0]        r_dn_key_id;
  logic                           r_busy;

  logic [IDX_W-1:0]               w_arb_grant;
  logic                           w_arb_valid;
  logic [KEY_ID_WIDTH-1:0]        w_sel_id;
  logic [NUM_PORTS-1:0]           w_grant_onehot;
  logic                           w_tmo_hit;

  key_req_arbiter_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .i_req   (up_key_req),
    .i_last  (r_last_grant),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  // Select the candidate's key id and decode the held grant to one-hot.
  always_comb begin
    w_sel_id       = '0;
    w_grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_arb_grant == IDX_W'(i)) w_sel_id = up_key_id[i*KEY_ID_WIDTH +: KEY_ID_WIDTH];
      w_grant_onehot[i] = (r_grant == IDX_W'(i));
    end
  end

  // Timeout fires only when no ack arrives in the last allowed cycle.
  always_comb begin
    w_tmo_hit = (r_state == ST_REQ) && !dn_key_ack && (r_tcnt == TMO_LAST);
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_arb_valid) w_next = ST_REQ;
      ST_REQ:     if (dn_key_ack || w_tmo_hit) w_next = ST_ACK;
      ST_ACK:     w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) r_state <= ST_IDLE;
    else               r_state <= w_next;
  end

  // Registered outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      r_grant         <= '0;
      r_last_grant    <= LAST_RST;
      r_tcnt          <= '0;
      r_timeout_count <= '0;
      r_up_key_ack    <= '0;
      r_up_key_err    <= '0;
      r_up_key        <= '0;
      r_dn_key_req    <= 1'b0;
      r_dn_key_id     <= '0;
      r_busy          <= 1'b0;
    end else begin
      r_dn_key_req <= (w_next == ST_REQ);
      r_busy       <= (w_next != ST_IDLE);
      r_up_key_ack <= '0;
      r_up_key_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_grant      <= w_arb_grant;
            r_last_grant <= w_arb_grant;
            r_dn_key_id  <= w_sel_id;
            r_tcnt       <= '0;
          end
        end
        ST_REQ: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (dn_key_ack) begin
            r_up_key     <= dn_key;
            r_up_key_ack <= w_grant_onehot;
          end else if (w_tmo_hit) begin
            r_up_key     <= '0;
            r_up_key_ack <= w_grant_onehot;
            r_up_key_err <= w_grant_onehot;
            if (r_timeout_count != '1) r_timeout_count <= r_timeout_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign up_key_ack    = r_up_key_ack;
  assign up_key_err    = r_up_key_err;
  assign up_key        = r_up_key;
  assign dn_key_req    = r_dn_key_req;
  assign dn_key_id     = r_dn_key_id;
  assign busy          = r_busy;
  assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_key_req_arbiter.sv
// Directed self-checking bench for key_req_arbiter (4 ports, 16-cycle timeout).
module tb_key_req_arbiter;

  logic         clk156;
  logic         areset_clk156;
  logic [3:0]   up_key_req;
  logic [127:0] up_key_id;
  logic [3:0]   up_key_ack;
  logic [3:0]   up_key_err;
  logic [255:0] up_key;
  logic         dn_key_req;
  logic [31:0]  dn_key_id;
  logic         dn_key_ack;
  logic [255:0] dn_key;
  logic         busy;
  logic [15:0]  timeout_count;

  int checks = 0;
  int errors = 0;

  key_req_arbiter #(
    .NUM_PORTS      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk156        (clk156),
    .areset_clk156 (areset_clk156),
    .up_key_req    (up_key_req),
    .up_key_id     (up_key_id),
    .up_key_ack    (up_key_ack),
    .up_key_err    (up_key_err),
    .up_key        (up_key),
    .dn_key_req    (dn_key_req),
    .dn_key_id     (dn_key_id),
    .dn_key_ack    (dn_key_ack),
    .dn_key        (dn_key),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic apply_reset();
    areset_clk156 = 1'b1;
    up_key_req    = '0;
    dn_key_ack    = 1'b0;
    dn_key        = '0;
    tick();
    tick();
    areset_clk156 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    up_key_req    = '0;
    up_key_id     = '0;
    dn_key_ack    = 1'b0;
    dn_key        = '0;
    areset_clk156 = 1'b1;
    #3;
    checks++;
    if (up_key_ack !== 4'b0 || up_key_err !== 4'b0) begin
      errors++; $display("FAIL reset_ack ack=%b err=%b expected 0000/0000", up_key_ack, up_key_err);
    end
    checks++;
    if (up_key !== 256'b0 || dn_key_id !== 32'b0) begin
      errors++; $display("FAIL reset_data up_key=%h dn_key_id=%h expected 0", up_key, dn_key_id);
    end
    checks++;
    if (dn_key_req !== 1'b0 || busy !== 1'b0 || timeout_count !== 16'd0) begin
      errors++; $display("FAIL reset_ctrl dn_req=%b busy=%b tcount=%0d expected 0/0/0", dn_key_req, busy, timeout_count);
    end
    tick();
    areset_clk156 = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [255:0] key;
    key = {32{8'hA5}};
    up_key_id[31:0] = 32'h0000_0005;
    up_key_req      = 4'b0001;
    tick();
    checks++;
    if (dn_key_req !== 1'b1 || dn_key_id !== 32'h5) begin
      errors++; $display("FAIL single_dn_req req=%b id=%h expected 1/00000005", dn_key_req, dn_key_id);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single_busy busy=%b expected 1", busy);
    end
    tick();
    tick();
    checks++;
    if (dn_key_req !== 1'b1 || up_key_ack !== 4'b0) begin
      errors++; $display("FAIL single_wait dn_req=%b ack=%b expected 1/0000", dn_key_req, up_key_ack);
    end
    dn_key_ack = 1'b1;
    dn_key     = key;
    tick();
    dn_key_ack = 1'b0;
    dn_key     = '0;
    checks++;
    if (up_key_ack !== 4'b0001 || up_key_err !== 4'b0000) begin
      errors++; $display("FAIL single_ack ack=%b err=%b expected 0001/0000", up_key_ack, up_key_err);
    end
    checks++;
    if (up_key !== key || dn_key_req !== 1'b0) begin
      errors++; $display("FAIL single_key key=%h dn_req=%b expected a5..a5/0", up_key, dn_key_req);
    end
    up_key_req = '0;
    tick();
    checks++;
    if (up_key_ack !== 4'b0 || busy !== 1'b1 || up_key !== key) begin
      errors++; $display("FAIL single_release ack=%b busy=%b key=%h expected 0000/1/a5..a5", up_key_ack, busy, up_key);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int hcnt;
    int n;
    up_key_id[95:64] = 32'h0000_0022;
    up_key_req       = 4'b0100;
    tick();
    hcnt = 0;
    n    = 0;
    while (dn_key_req === 1'b1 && n < 100) begin
      hcnt++;
      tick();
      n++;
    end
    checks++;
    if (hcnt != 16) begin
      errors++; $display("FAIL timeout_len high_cycles=%0d expected 16", hcnt);
    end
    checks++;
    if (up_key_ack !== 4'b0100 || up_key_err !== 4'b0100) begin
      errors++; $display("FAIL timeout_ack ack=%b err=%b expected 0100/0100", up_key_ack, up_key_err);
    end
    checks++;
    if (up_key !== 256'b0 || timeout_count !== 16'd1) begin
      errors++; $display("FAIL timeout_data key=%h tcount=%0d expected 0/1", up_key, timeout_count);
    end
    up_key_req = '0;
    dn_key_ack = 1'b1;
    dn_key     = {8{32'hBAD0_BAD0}};
    tick();
    checks++;
    if (up_key_ack !== 4'b0 || up_key_err !== 4'b0) begin
      errors++; $display("FAIL late_ack_release ack=%b err=%b expected 0000/0000", up_key_ack, up_key_err);
    end
    tick();
    tick();
    dn_key_ack = 1'b0;
    dn_key     = '0;
    checks++;
    if (up_key_ack !== 4'b0 || busy !== 1'b0 || dn_key_req !== 1'b0 || timeout_count !== 16'd1) begin
      errors++; $display("FAIL late_ack_idle ack=%b busy=%b dn_req=%b tcount=%0d expected 0000/0/0/1",
                         up_key_ack, busy, dn_key_req, timeout_count);
    end
  endtask

  task automatic test_ack_at_timeout();
    logic [255:0] key;
    key = {8{32'hDEAD_BEEF}};
    up_key_id[63:32] = 32'h0000_0011;
    up_key_req       = 4'b0010;
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (dn_key_req !== 1'b1 || dn_key_id !== 32'h11) begin
      errors++; $display("FAIL edge_still_req dn_req=%b id=%h expected 1/00000011", dn_key_req, dn_key_id);
    end
    dn_key_ack = 1'b1;
    dn_key     = key;
    tick();
    dn_key_ack = 1'b0;
    dn_key     = '0;
    checks++;
    if (up_key_ack !== 4'b0010 || up_key_err !== 4'b0000) begin
      errors++; $display("FAIL edge_ack ack=%b err=%b expected 0010/0000", up_key_ack, up_key_err);
    end
    checks++;
    if (up_key !== key || timeout_count !== 16'd1) begin
      errors++; $display("FAIL edge_data key=%h tcount=%0d expected deadbeef../1", up_key, timeout_count);
    end
    up_key_req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [255:0] key;
    logic         seen;
    key = {8{32'h1234_5678}};
    up_key_id[127:96] = 32'h0000_0033;
    up_key_req        = 4'b1000;
    tick();
    tick();
    checks++;
    if (dn_key_req !== 1'b1 || dn_key_id !== 32'h33) begin
      errors++; $display("FAIL rstmid_pre dn_req=%b id=%h expected 1/00000033", dn_key_req, dn_key_id);
    end
    #2;
    areset_clk156 = 1'b1;
    #1;
    checks++;
    if (dn_key_req !== 1'b0 || busy !== 1'b0 || dn_key_id !== 32'b0) begin
      errors++; $display("FAIL rstmid_ctrl dn_req=%b busy=%b id=%h expected 0/0/0", dn_key_req, busy, dn_key_id);
    end
    checks++;
    if (up_key !== 256'b0 || timeout_count !== 16'd0 || up_key_ack !== 4'b0) begin
      errors++; $display("FAIL rstmid_data key=%h tcount=%0d ack=%b expected 0/0/0000", up_key, timeout_count, up_key_ack);
    end
    tick();
    areset_clk156 = 1'b0;
    up_key_req    = '0;
    dn_key_ack    = 1'b1;
    dn_key        = key;
    seen          = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      dn_key_ack = 1'b0;
      if (up_key_ack !== 4'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_ack seen=%b expected 0", seen);
    end
    up_key_id[95:64] = 32'h2222_0002;
    up_key_req       = 4'b0100;
    tick();
    checks++;
    if (dn_key_req !== 1'b1 || dn_key_id !== 32'h2222_0002) begin
      errors++; $display("FAIL rstmid_new_req dn_req=%b id=%h expected 1/22220002", dn_key_req, dn_key_id);
    end
    dn_key_ack = 1'b1;
    dn_key     = key;
    tick();
    dn_key_ack = 1'b0;
    dn_key     = '0;
    checks++;
    if (up_key_ack !== 4'b0100 || up_key_err !== 4'b0 || up_key !== key) begin
      errors++; $display("FAIL rstmid_new_ack ack=%b err=%b key=%h expected 0100/0000/12345678..", up_key_ack, up_key_err, up_key);
    end
    up_key_req = '0;
    tick();
    tick();
  endtask

  task automatic test_all_ports();
    logic [255:0] key;
    logic [3:0]   mask;
    int           n;
    int           lowcnt;
    apply_reset();
    for (int i = 0; i < 4; i++) up_key_id[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    up_key_req = 4'b1111;
    tick();
    for (int p = 0; p < 4; p++) begin
      n      = 0;
      lowcnt = 0;
      while (dn_key_req !== 1'b1 && n < 20) begin
        lowcnt++;
        tick();
        n++;
      end
      checks++;
      if (dn_key_req !== 1'b1 || dn_key_id !== 32'h1000_0000 + 32'(p)) begin
        errors++; $display("FAIL all_grant%0d dn_req=%b id=%h expected 1/%h", p, dn_key_req, dn_key_id, 32'h1000_0000 + 32'(p));
      end
      if (p > 0) begin
        checks++;
        if (lowcnt != 2) begin
          errors++; $display("FAIL all_gap%0d low_cycles_after_ack=%0d expected 2", p, lowcnt);
        end
      end
      key        = {8{32'hC0DE_0000 + 32'(p)}};
      mask       = '0;
      mask[p]    = 1'b1;
      dn_key_ack = 1'b1;
      dn_key     = key;
      tick();
      dn_key_ack = 1'b0;
      dn_key     = '0;
      checks++;
      if (up_key_ack !== mask || up_key_err !== 4'b0 || up_key !== key) begin
        errors++; $display("FAIL all_ack%0d ack=%b err=%b key=%h expected %b/0000/%h", p, up_key_ack, up_key_err, up_key, mask, key);
      end
      up_key_req[p] = 1'b0;
      tick();
      checks++;
      if (up_key_ack !== 4'b0 || dn_key_req !== 1'b0) begin
        errors++; $display("FAIL all_pulse%0d ack=%b dn_req=%b expected 0000/0", p, up_key_ack, dn_key_req);
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    int unsigned seq [5];
    logic [3:0]  mask;
    int          n;
    seq = '{0, 1, 3, 0, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) up_key_id[i*32 +: 32] = 32'h5000_0000 + 32'(i);
    up_key_req = 4'b1011;
    for (int s = 0; s < 5; s++) begin
      n = 0;
      while (dn_key_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (dn_key_req !== 1'b1 || dn_key_id !== 32'h5000_0000 + seq[s]) begin
        errors++; $display("FAIL rr_grant%0d dn_req=%b id=%h expected 1/%h", s, dn_key_req, dn_key_id, 32'h5000_0000 + seq[s]);
      end
      mask          = '0;
      mask[seq[s]]  = 1'b1;
      dn_key_ack    = 1'b1;
      dn_key        = {64{4'h7}};
      tick();
      dn_key_ack    = 1'b0;
      checks++;
      if (up_key_ack !== mask) begin
        errors++; $display("FAIL rr_ack%0d ack=%b expected %b", s, up_key_ack, mask);
      end
      up_key_req[seq[s]] = 1'b0;
      tick();
      up_key_req[seq[s]] = 1'b1;
    end
    up_key_req = '0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_all_ports();
    test_round_robin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
